// File: rtl/firmware_loader_pkg.sv
// firmware_loader_pkg: shared FSM states and constants for the firmware loader
package firmware_loader_pkg;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam int DEF_ADDR_W = 14;
    localparam logic [15:0] MAX_LEN = 16'd16384;
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_ADDR_HI, S_ADDR_LO, S_PAYLOAD, S_CSUM, S_VERIFY
    } state_t;
endpackage

// File: rtl/firmware_loader_csum_m.sv
// firmware_loader_csum_m: 8-bit running-sum accumulator; zero tests the value being loaded this cycle
module firmware_loader_csum_m (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic       zero
);
    logic [7:0] sum, sum_next;
    assign sum_next = (clr ? 8'd0 : sum) + (add ? din : 8'd0);
    assign zero = sum_next == 8'd0;
    always_ff @(posedge clk) sum <= rst ? 8'd0 : sum_next;
endmodule

// File: rtl/firmware_loader_m.sv
// firmware_loader_m: framed host byte stream -> firmware RAM writes, holding the CPU while loading.
// FIRMWARE_LOADER_VERIFY_EN adds a readback pass comparing the stored bytes' sum to the received payload sum.
module firmware_loader_m
    import firmware_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wr_address,
    output logic [7:0]        wr_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] rd_address,
    input  logic [7:0]        rd_data,
    output logic              rd_select,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);
    state_t state, state_next;
    logic [7:0] hi;
    logic [14:0] cnt;
    logic [ADDR_W-1:0] addr;
    logic [15:0] word;
    logic fire, rx_ok, len_bad, last, verify_go;
    assign fire = in_valid && in_ready;
    assign word = {hi, in_data};
    assign len_bad = word > MAX_LEN;
    assign last = cnt == 15'd1;
    assign busy = state != S_IDLE;
    assign cpu_hold = busy;
    firmware_loader_csum_m u_rx (
        .clk(clk), .rst(rst), .clr(state == S_IDLE), .add(fire && busy), .din(in_data), .zero(rx_ok)
    );
`ifdef FIRMWARE_LOADER_VERIFY_EN
    logic [14:0] len;
    logic vf_ok;
    assign in_ready = state != S_VERIFY;
    assign rd_select = state == S_VERIFY;
    assign verify_go = rx_ok && len != '0;
    // Payload bytes are added, readback bytes subtracted: a clean store nets to zero
    firmware_loader_csum_m u_vf (
        .clk(clk), .rst(rst), .clr(state == S_IDLE),
        .add((state == S_PAYLOAD && fire) || rd_select),
        .din(rd_select ? ~rd_data + 8'd1 : in_data), .zero(vf_ok)
    );
`else
    logic unused_rd;
    assign unused_rd = ^rd_data;
    assign in_ready = 1'b1;
    assign rd_select = 1'b0;
    assign rd_address = '0;
    assign verify_go = 1'b0;
`endif
    always_ff @(posedge clk) state <= rst ? S_IDLE : state_next;
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (fire && in_data == SYNC_BYTE) state_next = S_LEN_HI;
            S_LEN_HI:  if (fire) state_next = S_LEN_LO;
            S_LEN_LO:  if (fire) state_next = len_bad ? S_IDLE : S_ADDR_HI;
            S_ADDR_HI: if (fire) state_next = S_ADDR_LO;
            S_ADDR_LO: if (fire) state_next = cnt == '0 ? S_CSUM : S_PAYLOAD;
            S_PAYLOAD: if (fire && last) state_next = S_CSUM;
            S_CSUM:    if (fire) state_next = verify_go ? S_VERIFY : S_IDLE;
            S_VERIFY:  if (last) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            cnt <= '0;
            addr <= '0;
            wr_en <= 1'b0;
            wr_address <= '0;
            wr_data <= '0;
            done <= 1'b0;
            error <= 1'b0;
`ifdef FIRMWARE_LOADER_VERIFY_EN
            len <= '0;
            rd_address <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (fire) begin
                if (state == S_IDLE && in_data == SYNC_BYTE) {done, error} <= 2'b00;
                if (state == S_LEN_HI || state == S_ADDR_HI) hi <= in_data;
                if (state == S_LEN_LO) begin
                    cnt <= word[14:0];
                    error <= len_bad;
`ifdef FIRMWARE_LOADER_VERIFY_EN
                    len <= word[14:0];
`endif
                end
                if (state == S_ADDR_LO) begin
                    addr <= word[ADDR_W-1:0];
`ifdef FIRMWARE_LOADER_VERIFY_EN
                    rd_address <= word[ADDR_W-1:0];
`endif
                end
                if (state == S_PAYLOAD) begin
                    wr_en <= 1'b1;
                    wr_address <= addr;
                    wr_data <= in_data;
                    addr <= addr + 1'b1;
                    cnt <= cnt - 1'b1;
                end
                if (state == S_CSUM) begin
                    done <= rx_ok && !verify_go;
                    error <= !rx_ok;
`ifdef FIRMWARE_LOADER_VERIFY_EN
                    cnt <= len;
`endif
                end
            end
`ifdef FIRMWARE_LOADER_VERIFY_EN
            if (state == S_VERIFY) begin
                rd_address <= rd_address + 1'b1;
                cnt <= cnt - 1'b1;
                if (last) begin
                    done <= vf_ok;
                    error <= !vf_ok;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_firmware_loader_m.sv
// tb_firmware_loader_m: directed frames; expected writes/status are queued at issue and checked by a negedge monitor
module tb_firmware_loader_m;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] in_data;
    logic in_valid;
    logic in_ready;
    logic [13:0] wr_address;
    logic [7:0] wr_data;
    logic wr_en;
    logic [13:0] rd_address;
    logic [7:0] rd_data;
    logic rd_select, busy, done, error, cpu_hold;

    logic [7:0] mem [0:16383];
    logic corrupt_en;
    logic [13:0] corrupt_addr;
    logic [21:0] wq[$];
    logic [17:0] sq[$];
    logic [7:0] pay[$];
    logic hung, finish_req;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    firmware_loader_m dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_address(wr_address), .wr_data(wr_data), .wr_en(wr_en), .rd_address(rd_address),
        .rd_data(rd_data), .rd_select(rd_select), .busy(busy), .done(done), .error(error),
        .cpu_hold(cpu_hold)
    );

    always @(posedge clk) if (wr_en) mem[wr_address] <= wr_data;
    assign rd_data = mem[rd_address] ^ ((corrupt_en && rd_address == corrupt_addr) ? 8'h01 : 8'h00);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic busy_q = 1'b0;
    logic rst_q = 1'b0;
    int vcnt = 0;
    always @(negedge clk) begin
        logic [21:0] we;
        logic [17:0] se;
        if (rst && rst_q)
            chk("reset", {in_ready, wr_en, busy, done, error, cpu_hold, rd_select, wr_address, wr_data, rd_address},
                {7'b1000000, 14'h0, 8'h0, 14'h0});
        if (wr_en) begin
            if (wq.size() == 0) chk("write_expected", 64'(wq.size()), 64'd1);
            else begin
                we = wq.pop_front();
                chk("write", {wr_address, wr_data}, we);
            end
        end else if (wq.size() != 0) begin
            we = wq.pop_front();
            chk("write_missing", {wr_en, wr_address, wr_data}, {1'b1, we});
        end
        if (!busy_q && busy) vcnt = 0;
        if (rd_select && !in_ready) vcnt++;
        if (busy_q && !busy) begin
            if (sq.size() == 0) chk("status_expected", 64'(sq.size()), 64'd1);
            else begin
                se = sq.pop_front();
                chk("status", {done, error, 16'(vcnt), cpu_hold, rd_select}, {se, 2'b00});
            end
        end
        busy_q = busy;
        rst_q = rst;
        if (finish_req) begin
            chk("writes_left", 64'(wq.size()), 64'd0);
            chk("status_left", 64'(sq.size()), 64'd0);
            chk("in_ready_wait", 64'(hung), 64'd0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $finish;
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) hung = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Checksum byte makes the sum of all bytes after SYNC zero; adj != 0 spoils it
    task automatic frame(input logic [15:0] addr, input logic [7:0] adj, input logic [1:0] st);
        logic [15:0] len;
        logic [7:0] s;
        int vlen;
        len = 16'(pay.size());
        vlen = 0;
`ifdef FIRMWARE_LOADER_VERIFY_EN
        if (adj == 8'h00 && len != 16'd0) vlen = int'(len);
`endif
        sq.push_back({st, 16'(vlen)});
        s = len[15:8] + len[7:0] + addr[15:8] + addr[7:0];
        send(8'hA5);
        send(len[15:8]);
        send(len[7:0]);
        send(addr[15:8]);
        send(addr[7:0]);
        foreach (pay[i]) begin
            s = s + pay[i];
            send(pay[i]);
            wq.push_back({addr[13:0] + 14'(i), pay[i]});
        end
        send(8'h00 - s + adj);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        hung = 1'b0;
        finish_req = 1'b0;
        corrupt_en = 1'b0;
        corrupt_addr = 14'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        send(8'h00);
        send(8'h3C);
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        frame(16'h0100, 8'h00, 2'b10);
        frame(16'h0100, 8'h01, 2'b01);
        pay = '{8'hAA, 8'hBB, 8'hCC};
        frame(16'h3FFF, 8'h00, 2'b10);
        pay = '{8'hA5, 8'hA5};
        frame(16'hC200, 8'h00, 2'b10);
        pay = '{};
        frame(16'h1234, 8'h00, 2'b10);
        sq.push_back({2'b01, 16'd0});
        send(8'hA5);
        send(8'h40);
        send(8'h01);
        idle(3);
        pay = '{8'h5A};
        frame(16'h0010, 8'h00, 2'b10);
        sq.push_back({2'b00, 16'd0});
        send(8'hA5);
        send(8'h00);
        send(8'h04);
        send(8'h01);
        send(8'h00);
        send(8'h55);
        wq.push_back({14'h0100, 8'h55});
        send(8'h66);
        wq.push_back({14'h0101, 8'h66});
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        pay = '{8'h77, 8'h88};
        frame(16'h0100, 8'h00, 2'b10);
`ifdef FIRMWARE_LOADER_VERIFY_EN
        pay = '{8'h01, 8'h02, 8'h03, 8'h04};
        frame(16'h0300, 8'h00, 2'b10);
        corrupt_addr = 14'h0302;
        corrupt_en = 1'b1;
        frame(16'h0300, 8'h00, 2'b01);
`endif
        idle(20);
        finish_req = 1'b1;
        idle(5);
    end
endmodule
